// File: rtl/tag_comparator.sv
// Tag comparator: pairs each tag FIFO entry with its DRAM metadata beat and issues one hit/miss
// result per request, keeping saturating hit/miss statistics and a sticky error flag.
module tag_comparator #(
    parameter int ADDR_W  = 58,
    parameter int ID_W    = 16,
    parameter int TAG_LSB = 30,
    parameter int TAG_W   = 28,
    parameter int META_W  = 64,
    parameter int FIFO_W  = 1 + ID_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tag_fifo_empty_i,
    input  logic [FIFO_W-1:0] tag_fifo_data_i,
    output logic              tag_fifo_rden_o,
    input  logic [ID_W-1:0]   rid_i,
    input  logic [META_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              res_hit_o,
    output logic              res_dirty_o,
    output logic [TAG_W-1:0]  res_victim_tag_o,
    output logic [ID_W-1:0]   res_id_o,
    output logic              res_is_write_o,
    output logic [ADDR_W-1:0] res_addr_o,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, WAIT_R, OUT} state_t;

    state_t             state_q, state_d;
    logic               is_write_q, is_write_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               hit_q, hit_d;
    logic               dirty_q, dirty_d;
    logic [TAG_W-1:0]   victim_tag_q, victim_tag_d;
    logic               err_q, err_d;
    logic [31:0]        hit_cnt_q, hit_cnt_d;
    logic [31:0]        miss_cnt_q, miss_cnt_d;

    logic               pop;
    logic               beat_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            is_write_q   <= 1'b0;
            id_q         <= '0;
            addr_q       <= '0;
            hit_q        <= 1'b0;
            dirty_q      <= 1'b0;
            victim_tag_q <= '0;
            err_q        <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            is_write_q   <= is_write_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            hit_q        <= hit_d;
            dirty_q      <= dirty_d;
            victim_tag_q <= victim_tag_d;
            err_q        <= err_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // A pop happens from IDLE, or from OUT in the same cycle the result is taken.
    always_comb begin
        pop         = 1'b0;
        rready_o    = (state_q == WAIT_R);
        res_valid_o = (state_q == OUT);
        if (!tag_fifo_empty_i && !rst) begin
            if (state_q == IDLE)
                pop = 1'b1;
            else if (state_q == OUT && res_ready_i)
                pop = 1'b1;
        end
        tag_fifo_rden_o = pop;
    end

    always_comb begin
        state_d      = state_q;
        is_write_d   = is_write_q;
        id_d         = id_q;
        addr_d       = addr_q;
        hit_d        = hit_q;
        dirty_d      = dirty_q;
        victim_tag_d = victim_tag_q;
        err_d        = err_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        beat_ok      = (rresp_i == 2'b00);

        case (state_q)
            IDLE: begin
                if (pop)
                    state_d = WAIT_R;
            end
            WAIT_R: begin
                if (rvalid_i) begin
                    state_d      = OUT;
                    hit_d        = beat_ok && rdata_i[META_W-1]
                                   && (rdata_i[TAG_W-1:0] == addr_q[TAG_LSB+TAG_W-1:TAG_LSB]);
                    dirty_d      = beat_ok && rdata_i[META_W-2];
                    victim_tag_d = rdata_i[TAG_W-1:0];
                    if (!beat_ok || rid_i != id_q)
                        err_d = 1'b1;
                end
            end
            OUT: begin
                if (res_ready_i) begin
                    state_d = pop ? WAIT_R : IDLE;
                    if (hit_q)
                        hit_cnt_d = (hit_cnt_q == 32'hFFFF_FFFF) ? hit_cnt_q : hit_cnt_q + 32'd1;
                    else
                        miss_cnt_d = (miss_cnt_q == 32'hFFFF_FFFF) ? miss_cnt_q : miss_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The popped entry is latched as the result is handed off, so outputs stay valid through OUT.
        if (pop) begin
            is_write_d = tag_fifo_data_i[FIFO_W-1];
            id_d       = tag_fifo_data_i[ID_W+ADDR_W-1:ADDR_W];
            addr_d     = tag_fifo_data_i[ADDR_W-1:0];
        end
    end

    assign res_hit_o        = hit_q;
    assign res_dirty_o      = dirty_q;
    assign res_victim_tag_o = victim_tag_q;
    assign res_id_o         = id_q;
    assign res_is_write_o   = is_write_q;
    assign res_addr_o       = addr_q;
    assign hit_cnt_o        = hit_cnt_q;
    assign miss_cnt_o       = miss_cnt_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_tag_comparator.sv
// Bench for tag_comparator: an FWFT FIFO and R-channel emulator feed the DUT while a request-level
// model predicts every result, counter and error flag; directed scenarios add literal expectations.
module tb_tag_comparator;

    localparam int ADDR_W  = 58;
    localparam int ID_W    = 16;
    localparam int TAG_LSB = 30;
    localparam int TAG_W   = 28;
    localparam int META_W  = 64;
    localparam int FIFO_W  = 1 + ID_W + ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tag_fifo_empty_i = 1'b1;
    logic [FIFO_W-1:0] tag_fifo_data_i = '0;
    logic              tag_fifo_rden_o;
    logic [ID_W-1:0]   rid_i = '0;
    logic [META_W-1:0] rdata_i = '0;
    logic [1:0]        rresp_i = '0;
    logic              rvalid_i = 1'b0;
    logic              rready_o;
    logic              res_valid_o;
    logic              res_ready_i = 1'b1;
    logic              res_hit_o;
    logic              res_dirty_o;
    logic [TAG_W-1:0]  res_victim_tag_o;
    logic [ID_W-1:0]   res_id_o;
    logic              res_is_write_o;
    logic [ADDR_W-1:0] res_addr_o;
    logic [31:0]       hit_cnt_o;
    logic [31:0]       miss_cnt_o;
    logic              err_o;

    tag_comparator dut (
        .clk(clk), .rst(rst),
        .tag_fifo_empty_i(tag_fifo_empty_i), .tag_fifo_data_i(tag_fifo_data_i),
        .tag_fifo_rden_o(tag_fifo_rden_o),
        .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_hit_o(res_hit_o),
        .res_dirty_o(res_dirty_o), .res_victim_tag_o(res_victim_tag_o), .res_id_o(res_id_o),
        .res_is_write_o(res_is_write_o), .res_addr_o(res_addr_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              is_write;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [META_W-1:0] data;
        logic [1:0]        resp;
    } beat_t;

    typedef struct {
        logic              hit;
        logic              dirty;
        logic [TAG_W-1:0]  victim;
        logic [ID_W-1:0]   id;
        logic              is_write;
        logic [ADDR_W-1:0] addr;
    } result_t;

    entry_t  fifo_q[$];
    beat_t   beat_q[$];
    entry_t  pending_q[$];
    result_t exp_q[$];
    int      hs_cycles[$];

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    logic [31:0] m_hit = 0;
    logic [31:0] m_miss = 0;
    logic        m_err = 1'b0;
    bit          pop_fifo = 0;
    bit          pop_beat = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic refresh_inputs();
        tag_fifo_empty_i = (fifo_q.size() == 0);
        tag_fifo_data_i  = '0;
        if (fifo_q.size() != 0)
            tag_fifo_data_i = {fifo_q[0].is_write, fifo_q[0].id, fifo_q[0].addr};
        rvalid_i = (beat_q.size() != 0);
        rid_i    = '0;
        rdata_i  = '0;
        rresp_i  = '0;
        if (beat_q.size() != 0) begin
            rid_i   = beat_q[0].id;
            rdata_i = beat_q[0].data;
            rresp_i = beat_q[0].resp;
        end
    endtask

    // Request-level model: one result per popped entry, computed from the tag rules.
    function automatic result_t predict(input entry_t e, input beat_t b);
        result_t r;
        logic [TAG_W-1:0] req_tag;
        req_tag    = TAG_W'(e.addr >> TAG_LSB);
        r.victim   = b.data[TAG_W-1:0];
        r.hit      = (b.resp == 0) && b.data[63] && (r.victim == req_tag);
        r.dirty    = (b.resp == 0) ? b.data[62] : 1'b0;
        r.id       = e.id;
        r.is_write = e.is_write;
        r.addr     = e.addr;
        return r;
    endfunction

    // Single compare process: checks outputs against the model, then records this cycle's transfers.
    always @(negedge clk) begin
        cycle++;
        pop_fifo = 0;
        pop_beat = 0;
        if (rst) begin
            pending_q.delete();
            exp_q.delete();
            m_hit  = 0;
            m_miss = 0;
            m_err  = 1'b0;
        end else begin
            checkOutput("err_o", {63'd0, err_o}, {63'd0, m_err});
            checkOutput("hit_cnt", {32'd0, hit_cnt_o}, {32'd0, m_hit});
            checkOutput("miss_cnt", {32'd0, miss_cnt_o}, {32'd0, m_miss});
            checkOutput("rden_when_empty", {63'd0, tag_fifo_rden_o & tag_fifo_empty_i}, 64'd0);
            if (res_valid_o) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_result", 64'd1, 64'd0);
                end else begin
                    checkOutput("res_hit", {63'd0, res_hit_o}, {63'd0, exp_q[0].hit});
                    checkOutput("res_dirty", {63'd0, res_dirty_o}, {63'd0, exp_q[0].dirty});
                    checkOutput("res_victim", {36'd0, res_victim_tag_o}, {36'd0, exp_q[0].victim});
                    checkOutput("res_id", {48'd0, res_id_o}, {48'd0, exp_q[0].id});
                    checkOutput("res_is_write", {63'd0, res_is_write_o}, {63'd0, exp_q[0].is_write});
                    checkOutput("res_addr", {6'd0, res_addr_o}, {6'd0, exp_q[0].addr});
                end
                if (!res_ready_i) begin
                    checkOutput("bp_rden", {63'd0, tag_fifo_rden_o}, 64'd0);
                    checkOutput("bp_rready", {63'd0, rready_o}, 64'd0);
                end else if (exp_q.size() != 0) begin
                    result_t r;
                    r = exp_q.pop_front();
                    if (r.hit) begin
                        if (m_hit != 32'hFFFF_FFFF) m_hit = m_hit + 1;
                    end else begin
                        if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
                    end
                    hs_cycles.push_back(cycle);
                end
            end
            if (tag_fifo_rden_o && !tag_fifo_empty_i) begin
                pending_q.push_back(fifo_q[0]);
                pop_fifo = 1;
            end
            if (rready_o && rvalid_i) begin
                pop_beat = 1;
                if (pending_q.size() == 0) begin
                    checkOutput("beat_without_request", 64'd1, 64'd0);
                end else begin
                    entry_t e;
                    e = pending_q.pop_front();
                    exp_q.push_back(predict(e, beat_q[0]));
                    if (beat_q[0].id != e.id || beat_q[0].resp != 0)
                        m_err = 1'b1;
                end
            end
        end
    end

    // FIFO / R-channel emulator: retire what the DUT took at this edge.
    always @(posedge clk) begin
        entry_t e;
        beat_t  b;
        #1;
        if (pop_fifo && fifo_q.size() != 0) e = fifo_q.pop_front();
        if (pop_beat && beat_q.size() != 0) b = beat_q.pop_front();
        pop_fifo = 0;
        pop_beat = 0;
        refresh_inputs();
    end

    task automatic applyStimulus(input bit add_entry, input logic is_write, input logic [ID_W-1:0] id,
                                 input logic [ADDR_W-1:0] addr, input bit add_beat,
                                 input logic [ID_W-1:0] rid, input logic [META_W-1:0] data,
                                 input logic [1:0] resp);
        entry_t e;
        beat_t  b;
        @(posedge clk);
        #2;
        if (add_entry) begin
            e.is_write = is_write; e.id = id; e.addr = addr;
            fifo_q.push_back(e);
        end
        if (add_beat) begin
            b.id = rid; b.data = data; b.resp = resp;
            beat_q.push_back(b);
        end
        refresh_inputs();
    endtask

    task automatic wait_result(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) checkOutput("result_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && pending_q.size() == 0 && fifo_q.size() == 0 && !res_valid_o) begin
                done = 1;
                break;
            end
        end
        if (!done) checkOutput("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_rden"}, {63'd0, tag_fifo_rden_o}, 64'd0);
        checkOutput({tag, "_rready"}, {63'd0, rready_o}, 64'd0);
        checkOutput({tag, "_valid"}, {63'd0, res_valid_o}, 64'd0);
        checkOutput({tag, "_hit"}, {63'd0, res_hit_o}, 64'd0);
        checkOutput({tag, "_dirty"}, {63'd0, res_dirty_o}, 64'd0);
        checkOutput({tag, "_victim"}, {36'd0, res_victim_tag_o}, 64'd0);
        checkOutput({tag, "_id"}, {48'd0, res_id_o}, 64'd0);
        checkOutput({tag, "_addr"}, {6'd0, res_addr_o}, 64'd0);
        checkOutput({tag, "_is_write"}, {63'd0, res_is_write_o}, 64'd0);
        checkOutput({tag, "_hit_cnt"}, {32'd0, hit_cnt_o}, 64'd0);
        checkOutput({tag, "_miss_cnt"}, {32'd0, miss_cnt_o}, 64'd0);
        checkOutput({tag, "_err"}, {63'd0, err_o}, 64'd0);
    endtask

    initial begin
        bit ok;
        int n;
        $display("[TB] starting tag_comparator bench");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // Hit read: tag of 0x4000_0040 is 1.
        applyStimulus(1, 1'b0, 16'd5, 58'h4000_0040, 1, 16'd5, 64'h8000_0000_0000_0001, 2'd0);
        wait_result(ok);
        checkOutput("t1_hit", {63'd0, res_hit_o}, 64'd1);
        checkOutput("t1_id", {48'd0, res_id_o}, 64'd5);
        checkOutput("t1_is_write", {63'd0, res_is_write_o}, 64'd0);
        @(negedge clk);
        checkOutput("t1_hit_cnt", {32'd0, hit_cnt_o}, 64'd1);

        // Dirty miss on a write: request tag 2, stored tag 5.
        applyStimulus(1, 1'b1, 16'd7, 58'h8000_0000, 1, 16'd7, 64'hC000_0000_0000_0005, 2'd0);
        wait_result(ok);
        checkOutput("t2_hit", {63'd0, res_hit_o}, 64'd0);
        checkOutput("t2_dirty", {63'd0, res_dirty_o}, 64'd1);
        checkOutput("t2_victim", {36'd0, res_victim_tag_o}, 64'd5);
        checkOutput("t2_is_write", {63'd0, res_is_write_o}, 64'd1);
        @(negedge clk);
        checkOutput("t2_miss_cnt", {32'd0, miss_cnt_o}, 64'd1);

        // Invalid metadata with a matching tag still misses and reports the dirty bit.
        applyStimulus(1, 1'b0, 16'd3, 58'h4000_0040, 1, 16'd3, 64'h4000_0000_0000_0001, 2'd0);
        wait_result(ok);
        checkOutput("t3_hit", {63'd0, res_hit_o}, 64'd0);
        checkOutput("t3_dirty", {63'd0, res_dirty_o}, 64'd1);
        wait_drain();

        // Backpressure then back-to-back: ids 10..13, even ones hit.
        res_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [META_W-1:0] d;
            d = 64'h8000_0000_0000_0000 | ((i % 2 == 0) ? 64'(i) : 64'(i + 100));
            applyStimulus(1, i[0], 16'(10 + i), 58'(i) << TAG_LSB, 1, 16'(10 + i), d, 2'd0);
        end
        wait_result(ok);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t4_hold_valid", {63'd0, res_valid_o}, 64'd1);
            checkOutput("t4_hold_id", {48'd0, res_id_o}, 64'd10);
            checkOutput("t4_hold_rden", {63'd0, tag_fifo_rden_o}, 64'd0);
            checkOutput("t4_hold_rready", {63'd0, rready_o}, 64'd0);
        end
        @(posedge clk);
        #2 res_ready_i = 1'b1;
        wait_drain();
        n = hs_cycles.size();
        for (int k = n - 3; k < n; k++)
            checkOutput("t4_gap", 64'(hs_cycles[k] - hs_cycles[k-1]), 64'd2);
        checkOutput("t4_hit_cnt", {32'd0, hit_cnt_o}, 64'd3);
        checkOutput("t4_miss_cnt", {32'd0, miss_cnt_o}, 64'd4);

        // ID mismatch sets the sticky error but the hit still stands; bad rresp forces a clean miss.
        applyStimulus(1, 1'b0, 16'd5, 58'h4000_0040, 1, 16'd9, 64'h8000_0000_0000_0001, 2'd0);
        wait_result(ok);
        checkOutput("t5_hit", {63'd0, res_hit_o}, 64'd1);
        checkOutput("t5_err", {63'd0, err_o}, 64'd1);
        wait_drain();
        applyStimulus(1, 1'b0, 16'd6, 58'h4000_0040, 1, 16'd6, 64'hC000_0000_0000_0001, 2'd2);
        wait_result(ok);
        checkOutput("t5b_hit", {63'd0, res_hit_o}, 64'd0);
        checkOutput("t5b_dirty", {63'd0, res_dirty_o}, 64'd0);
        checkOutput("t5b_err", {63'd0, err_o}, 64'd1);
        wait_drain();
        checkOutput("t5_hit_cnt", {32'd0, hit_cnt_o}, 64'd4);
        checkOutput("t5_miss_cnt", {32'd0, miss_cnt_o}, 64'd5);

        // Reset while waiting for R drops the request.
        applyStimulus(1, 1'b0, 16'd5, 58'h4000_0040, 0, 16'd0, 64'd0, 2'd0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rready_o) begin
                ok = 1;
                break;
            end
        end
        checkOutput("t6_reached_wait_r", {63'd0, ok}, 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_reset");
        @(posedge clk);
        #2 rst = 1'b0;
        applyStimulus(1, 1'b1, 16'h22, 58'hC000_0000, 1, 16'h22, 64'h8000_0000_0000_0003, 2'd0);
        wait_result(ok);
        checkOutput("t6_hit", {63'd0, res_hit_o}, 64'd1);
        checkOutput("t6_id", {48'd0, res_id_o}, 64'h22);
        checkOutput("t6_is_write", {63'd0, res_is_write_o}, 64'd1);
        wait_drain();
        checkOutput("t6_hit_cnt", {32'd0, hit_cnt_o}, 64'd1);
        checkOutput("t6_err", {63'd0, err_o}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
